// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU phase sequencer: the state index encoding
// and the width helpers used to size its registers and ports.
package cpu_seq_pkg;

    // FETCH is index 0, EXECi is index i, HALTED is MAX_EXEC+1.
    localparam int ST_FETCH = 0;

    function automatic int st_halted(input int max_exec);
        return max_exec + 1;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic int clog2_min1(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/instr_counter.sv
// Retired-instruction counter: wraps modulo 2^W; clear has priority over enable.
module instr_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction phase sequencer: FETCH, a variable number of EXEC phases chosen
// in EXEC1, and a HALTED state entered at retirement on request.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter  int MAX_EXEC = 3,
    parameter  int CNT_W    = 16,
    localparam int XW       = clog2_min1(MAX_EXEC)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                P,
    input  logic [XW-1:0]       EXTRA,
    input  logic                HALT,
    input  logic                RESUME,
    output logic                FETCH,
    output logic [MAX_EXEC-1:0] EXEC,
    output logic                LAST_EXEC,
    output logic                HALTED,
    output logic [CNT_W-1:0]    INSTR_COUNT
);

    localparam int SW = clog2(MAX_EXEC + 2);

    localparam logic [SW-1:0] S_FETCH  = SW'(ST_FETCH);
    localparam logic [SW-1:0] S_EXEC1  = SW'(1);
    localparam logic [SW-1:0] S_LAST   = SW'(MAX_EXEC);
    localparam logic [SW-1:0] S_HALTED = SW'(st_halted(MAX_EXEC));
    localparam logic [XW-1:0] X_MAX    = XW'(MAX_EXEC - 1);

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic [XW-1:0] extra_q;
    logic [XW-1:0] extra_d;

    logic          in_exec;
    logic          retire;
    logic [XW-1:0] extra_live;
    logic [XW-1:0] extra_cur;
    logic [SW-1:0] target;

    // EXEC1 sees the live (clamped) EXTRA; later phases use the value latched leaving EXEC1.
    always_comb begin
        extra_live = (EXTRA > X_MAX) ? X_MAX : EXTRA;
        extra_cur  = (state_q == S_EXEC1) ? extra_live : extra_q;
        target     = SW'(extra_cur) + SW'(1);
        in_exec    = (state_q >= S_EXEC1) && (state_q <= S_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_FETCH;
            extra_q <= '0;
        end else begin
            state_q <= state_d;
            extra_q <= extra_d;
        end
    end

    always_comb begin
        state_d = state_q;
        extra_d = extra_q;
        retire  = 1'b0;
        if (state_q == S_FETCH) begin
            if (P) begin
                state_d = S_EXEC1;
            end
        end else if (in_exec) begin
            if (P) begin
                if (state_q == S_EXEC1) begin
                    extra_d = extra_live;
                end
                if (state_q == target) begin
                    retire  = 1'b1;
                    state_d = HALT ? S_HALTED : S_FETCH;
                end else begin
                    state_d = state_q + SW'(1);
                end
            end
        end else if (state_q == S_HALTED) begin
            if (RESUME) begin
                state_d = S_FETCH;
            end
        end else begin
            state_d = S_FETCH;
        end
    end

    always_comb begin
        FETCH     = (state_q == S_FETCH);
        HALTED    = (state_q == S_HALTED);
        LAST_EXEC = in_exec && (state_q == target);
        for (int i = 0; i < MAX_EXEC; i++) begin
            EXEC[i] = (state_q == SW'(i + 1));
        end
    end

    instr_counter #(
        .W (CNT_W)
    ) u_instr_counter (
        .clk   (CLK),
        .clr   (RESET),
        .en    (retire),
        .count (INSTR_COUNT)
    );

endmodule
